// File: rtl/param_seq_detector.sv
// -----------------------------------------------------------------------------
// param_seq_detector
//
// Purpose:
//   Serial bit-sequence detector with a pattern and length that can be changed
//   at run time (1..MAX_LEN bits). Overlapping matches can be allowed or not.
//   Bits are only taken when x_valid is high. A one-cycle registered pulse on z
//   flags each match, and a saturating counter keeps a tally of matches. After
//   reset the block looks for the sequence 1,0,0,0.
//
// Parameters:
//   MAX_LEN      longest supported pattern, 2..16 bits
//   LEN_W        width of len_in; must be wide enough to hold MAX_LEN
//   CNT_W        width of the match counter
//   DEFAULT_PAT  pattern after reset (only the low DEFAULT_LEN bits matter)
//   DEFAULT_LEN  pattern length after reset
//
// Ports:
//   CLK        in   clock, every register updates on the rising edge
//   RESET      in   asynchronous reset, active-high
//   x_valid    in   qualifier; x is taken only when this is high
//   x          in   serial data bit
//   pat_load   in   load pat_in/len_in/overlap_in and restart detection
//   pat_in     in   pattern; pat_in[len-1] is the first bit, pat_in[0] the last
//   len_in     in   pattern length (0/1 treated as 1, above MAX_LEN as MAX_LEN)
//   overlap_in in   1 = overlapping matches allowed, 0 = restart after a match
//   cnt_clr    in   synchronous clear of match_cnt (wins over a coincident match)
//   z          out  registered one-cycle match pulse
//   match_cnt  out  number of matches, saturates at all-ones
//   cnt_sat    out  high while match_cnt is all-ones
// -----------------------------------------------------------------------------
module param_seq_detector #(
  parameter int                 MAX_LEN     = 8,
  parameter int                 LEN_W       = 4,
  parameter int                 CNT_W       = 8,
  parameter logic [MAX_LEN-1:0] DEFAULT_PAT = 8'b0000_1000,
  parameter int                 DEFAULT_LEN = 4
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               x_valid,
  input  logic               x,
  input  logic               pat_load,
  input  logic [MAX_LEN-1:0] pat_in,
  input  logic [LEN_W-1:0]   len_in,
  input  logic               overlap_in,
  input  logic               cnt_clr,
  output logic               z,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               cnt_sat
);

  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);
  localparam logic [LEN_W-1:0] LEN_RST = LEN_W'(DEFAULT_LEN);
  localparam logic [CNT_W-1:0] CNT_ALL = {CNT_W{1'b1}};

  // Programmed configuration
  logic [MAX_LEN-1:0] pattern;
  logic [LEN_W-1:0]   len;
  logic               overlap;

  // Detection state: recent bits (newest at bit 0) and the number of bits
  // collected since the last restart, capped at len.
  logic [MAX_LEN-1:0] hist;
  logic [LEN_W-1:0]   fill;

  // Next-state values
  logic [MAX_LEN-1:0] pattern_n;
  logic [LEN_W-1:0]   len_n;
  logic               overlap_n;
  logic [MAX_LEN-1:0] hist_n;
  logic [LEN_W-1:0]   fill_n;
  logic               z_n;
  logic [CNT_W-1:0]   cnt_n;
  logic               sat_n;

  // Helper terms
  logic [MAX_LEN-1:0] hist_shift;
  logic [MAX_LEN-1:0] len_mask;
  logic [LEN_W:0]     fill_plus;
  logic               window_full;
  logic [LEN_W-1:0]   fill_sat;
  logic               accept;
  logic               is_match;
  logic [LEN_W-1:0]   len_clamped;

  // Mask that selects the low len bits of the history and the pattern.
  // Bits above len are don't-care, so patterns of any length share one
  // comparator.
  always_comb begin
    len_mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      len_mask[i] = (i < int'(len));
    end
  end

  // Match detection works on the history value after the shift, so the
  // pulse can be registered on the same edge that samples the final bit.
  // fill is one wider here so that fill+1 cannot wrap when len is at the
  // top of the LEN_W range.
  always_comb begin
    accept      = x_valid && !pat_load;
    hist_shift  = {hist[MAX_LEN-2:0], x};
    fill_plus   = {1'b0, fill} + (LEN_W+1)'(1);
    window_full = (fill_plus >= {1'b0, len});
    fill_sat    = window_full ? len : fill_plus[LEN_W-1:0];
    is_match    = accept && window_full &&
                  (((hist_shift ^ pattern) & len_mask) == '0);
  end

  // Clamp a requested length into 1..MAX_LEN. A length of zero would have
  // no meaning, so it is treated the same as a single-bit pattern.
  always_comb begin
    if (len_in <= LEN_ONE) begin
      len_clamped = LEN_ONE;
    end else if (len_in > LEN_MAX) begin
      len_clamped = LEN_MAX;
    end else begin
      len_clamped = len_in;
    end
  end

  // Next-state logic. pat_load beats x_valid. A load throws away the history
  // and any partial sequence, so bits from before the load can never take
  // part in a match. In non-overlap mode a match sets fill back to zero and
  // leaves hist alone. The following match then needs len new bits, because
  // the stale bits still in hist fail the fill check. The counter is separate
  // from loads. cnt_clr wins over a match in the same cycle, but z still
  // pulses.
  always_comb begin
    pattern_n = pattern;
    len_n     = len;
    overlap_n = overlap;
    hist_n    = hist;
    fill_n    = fill;
    z_n       = 1'b0;
    cnt_n     = match_cnt;
    sat_n     = 1'b0;

    if (pat_load) begin
      pattern_n = pat_in;
      len_n     = len_clamped;
      overlap_n = overlap_in;
      hist_n    = '0;
      fill_n    = '0;
    end else if (x_valid) begin
      hist_n = hist_shift;
      z_n    = is_match;
      if (is_match && !overlap) begin
        fill_n = '0;
      end else begin
        fill_n = fill_sat;
      end
    end

    if (cnt_clr) begin
      cnt_n = '0;
    end else if (is_match && (match_cnt != CNT_ALL)) begin
      cnt_n = match_cnt + CNT_W'(1);
    end

    sat_n = (cnt_n == CNT_ALL);
  end

  // State register. Reset brings back the default pattern right away, so
  // the block can detect without any setup first.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      pattern   <= DEFAULT_PAT;
      len       <= LEN_RST;
      overlap   <= 1'b0;
      hist      <= '0;
      fill      <= '0;
      z         <= 1'b0;
      match_cnt <= '0;
      cnt_sat   <= 1'b0;
    end else begin
      pattern   <= pattern_n;
      len       <= len_n;
      overlap   <= overlap_n;
      hist      <= hist_n;
      fill      <= fill_n;
      z         <= z_n;
      match_cnt <= cnt_n;
      cnt_sat   <= sat_n;
    end
  end

endmodule

// File: tb/tb_param_seq_detector.sv
// -----------------------------------------------------------------------------
// tb_param_seq_detector
//
// Purpose:
//   Self-checking bench for param_seq_detector. It builds two instances, one
//   with the default 8-bit counter and one with a 2-bit counter, and drives
//   both with the same inputs. A behavioural model keeps the bits accepted
//   since the last restart in a queue and compares the tail of that queue
//   against the pattern. Directed scenarios come first, then a randomized run.
//
// Ports: none (top-level bench).
// -----------------------------------------------------------------------------
module tb_param_seq_detector;

  logic       CLK;
  logic       RESET;
  logic       x_valid;
  logic       x;
  logic       pat_load;
  logic [7:0] pat_in;
  logic [3:0] len_in;
  logic       overlap_in;
  logic       cnt_clr;

  logic       z;
  logic [7:0] match_cnt;
  logic       cnt_sat;
  logic       z_small;
  logic [1:0] match_cnt_small;
  logic       cnt_sat_small;

  int checks;
  int failures;

  // Reference model state
  bit       fresh[$];
  int       m_len;
  bit       m_overlap;
  bit [7:0] m_pat;
  bit       exp_z;
  int       exp_cnt;
  int       exp_cnt_small;

  param_seq_detector dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .x_valid    (x_valid),
    .x          (x),
    .pat_load   (pat_load),
    .pat_in     (pat_in),
    .len_in     (len_in),
    .overlap_in (overlap_in),
    .cnt_clr    (cnt_clr),
    .z          (z),
    .match_cnt  (match_cnt),
    .cnt_sat    (cnt_sat)
  );

  param_seq_detector #(.CNT_W(2)) dut_small (
    .CLK        (CLK),
    .RESET      (RESET),
    .x_valid    (x_valid),
    .x          (x),
    .pat_load   (pat_load),
    .pat_in     (pat_in),
    .len_in     (len_in),
    .overlap_in (overlap_in),
    .cnt_clr    (cnt_clr),
    .z          (z_small),
    .match_cnt  (match_cnt_small),
    .cnt_sat    (cnt_sat_small)
  );

  // Free-running clock with a 10-unit period
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Count one comparison and report it if it does not match
  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d at t=%0t",
               tag, observed, expected, $time);
    end
  endtask

  // Match when at least len bits have arrived since the last restart and the
  // most recent len of them spell the pattern, first bit = pat[len-1]
  function automatic bit model_match();
    int n;
    n = fresh.size();
    if (n < m_len) return 1'b0;
    for (int i = 0; i < m_len; i++) begin
      if (fresh[n - m_len + i] != m_pat[m_len - 1 - i]) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic void model_reset();
    fresh.delete();
    m_len         = 4;
    m_pat         = 8'b0000_1000;
    m_overlap     = 1'b0;
    exp_z         = 1'b0;
    exp_cnt       = 0;
    exp_cnt_small = 0;
  endfunction

  // One clock: advance the model with the inputs present at the edge, then
  // compare all outputs 1 unit later
  task automatic run_cycle();
    bit m;
    int l;
    @(posedge CLK);
    m = 1'b0;
    if (pat_load) begin
      l = int'(len_in);
      if (l < 1) l = 1;
      if (l > 8) l = 8;
      m_len     = l;
      m_pat     = pat_in;
      m_overlap = overlap_in;
      fresh.delete();
    end else if (x_valid) begin
      fresh.push_back(x);
      if (fresh.size() > 16) void'(fresh.pop_front());
      m = model_match();
      if (m && !m_overlap) fresh.delete();
    end
    exp_z = m;
    if (cnt_clr) begin
      exp_cnt       = 0;
      exp_cnt_small = 0;
    end else if (m) begin
      if (exp_cnt < 255) exp_cnt++;
      if (exp_cnt_small < 3) exp_cnt_small++;
    end
    #1;
    check_output("z", z, exp_z);
    check_output("match_cnt", match_cnt, exp_cnt);
    check_output("cnt_sat", cnt_sat, exp_cnt == 255);
    check_output("z_small", z_small, exp_z);
    check_output("match_cnt_small", match_cnt_small, exp_cnt_small);
    check_output("cnt_sat_small", cnt_sat_small, exp_cnt_small == 3);
  endtask

  task automatic apply_stimulus(input logic v, input logic b);
    x_valid = v;
    x       = b;
    run_cycle();
    x_valid = 1'b0;
  endtask

  task automatic send_bits(input bit [15:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) apply_stimulus(1'b1, bits[i]);
  endtask

  task automatic load_pattern(input logic [7:0] p, input logic [3:0] l,
                              input logic ov);
    pat_load   = 1'b1;
    pat_in     = p;
    len_in     = l;
    overlap_in = ov;
    run_cycle();
    pat_load   = 1'b0;
  endtask

  // Reset in the middle of a cycle. The outputs have to drop before the
  // next clock edge.
  task automatic do_reset();
    RESET = 1'b1;
    #1;
    check_output("async_z", z, 0);
    check_output("async_cnt", match_cnt, 0);
    check_output("async_sat", cnt_sat, 0);
    check_output("async_cnt_small", match_cnt_small, 0);
    model_reset();
    @(posedge CLK);
    #2;
    RESET = 1'b0;
  endtask

  initial begin
    int exp_seq[5];
    checks     = 0;
    failures   = 0;
    RESET      = 1'b1;
    x_valid    = 1'b0;
    x          = 1'b0;
    pat_load   = 1'b0;
    pat_in     = 8'h00;
    len_in     = 4'd0;
    overlap_in = 1'b0;
    cnt_clr    = 1'b0;
    model_reset();
    #12;
    check_output("reset_z", z, 0);
    check_output("reset_cnt", match_cnt, 0);
    check_output("reset_sat", cnt_sat, 0);
    RESET = 1'b0;
    #1;

    // Default pattern 1000: matches end on the 4th and the 9th bits
    $display("[TB] default pattern after reset");
    send_bits(16'b1_0000_1000, 9);
    check_output("t1_cnt", match_cnt, 2);

    // 101 with and without overlap
    $display("[TB] overlap modes");
    cnt_clr = 1'b1; apply_stimulus(1'b0, 1'b0); cnt_clr = 1'b0;
    load_pattern(8'b101, 4'd3, 1'b1);
    send_bits(16'b10101, 5);
    check_output("t2_overlap_cnt", match_cnt, 2);
    cnt_clr = 1'b1; apply_stimulus(1'b0, 1'b0); cnt_clr = 1'b0;
    load_pattern(8'b101, 4'd3, 1'b0);
    send_bits(16'b10101, 5);
    check_output("t2_nooverlap_cnt", match_cnt, 1);

    // Gapped input: 3 idle cycles between bits
    $display("[TB] gapped input");
    load_pattern(8'b1000, 4'd4, 1'b0);
    for (int i = 3; i >= 0; i--) begin
      apply_stimulus(1'b1, (i == 3));
      if (i != 0) for (int k = 0; k < 3; k++) apply_stimulus(1'b0, 1'b1);
    end
    check_output("t3_gap_z", z, 1);
    apply_stimulus(1'b0, 1'b0);
    check_output("t3_gap_z_gone", z, 0);

    // Reload in the middle of a sequence abandons the partial match
    $display("[TB] mid-sequence reload and reset");
    send_bits(16'b100, 3);
    x_valid = 1'b1; x = 1'b0;
    load_pattern(8'b1000, 4'd4, 1'b0);
    send_bits(16'b1000, 4);
    check_output("t4_reload_z", z, 1);
    send_bits(16'b100, 3);
    do_reset();
    send_bits(16'b1000, 4);
    check_output("t4_reset_z", z, 1);
    do_reset();

    // Length bounds
    $display("[TB] length bounds");
    load_pattern(8'b0000_0001, 4'd0, 1'b0);
    send_bits(16'b1101, 4);
    check_output("t5_len0_cnt", match_cnt, 3);
    load_pattern(8'hA5, 4'd15, 1'b0);
    send_bits(16'hA5, 8);
    check_output("t5_len15_z", z, 1);

    // Counter saturation on the 2-bit instance, then cnt_clr with a match
    $display("[TB] counter saturation");
    cnt_clr = 1'b1;
    load_pattern(8'b1, 4'd1, 1'b1);
    cnt_clr = 1'b0;
    exp_seq = '{1, 2, 3, 3, 3};
    for (int i = 0; i < 5; i++) begin
      apply_stimulus(1'b1, 1'b1);
      check_output("t6_small_cnt", match_cnt_small, exp_seq[i]);
    end
    check_output("t6_small_sat", cnt_sat_small, 1);
    cnt_clr = 1'b1; apply_stimulus(1'b1, 1'b1); cnt_clr = 1'b0;
    check_output("t6_clr_z", z, 1);
    check_output("t6_clr_cnt", match_cnt, 0);
    for (int i = 0; i < 260; i++) apply_stimulus(1'b1, 1'b1);
    check_output("t6_wide_cnt", match_cnt, 255);
    check_output("t6_wide_sat", cnt_sat, 1);
    cnt_clr = 1'b1; apply_stimulus(1'b0, 1'b0); cnt_clr = 1'b0;

    // Randomized traffic: occasional reloads, gaps, clears and resets
    $display("[TB] random traffic");
    for (int c = 0; c < 4000; c++) begin
      pat_in     = 8'($urandom);
      len_in     = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                               : 4'($urandom_range(1, 4));
      overlap_in = 1'($urandom);
      cnt_clr    = ($urandom_range(0, 60) == 0);
      if ($urandom_range(0, 800) == 0) begin
        do_reset();
      end else begin
        pat_load = ($urandom_range(0, 40) == 0);
        x_valid  = ($urandom_range(0, 3) != 0);
        x        = ($urandom_range(0, 2) != 0);
        run_cycle();
        pat_load = 1'b0;
      end
    end
    cnt_clr = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
